// File: rtl/generador_figuras_param.sv
// generador_figuras_param: registered N-box rectangle generator with per-box fill/border/blink for the 640x480 VGA path
//   clk, reset (async, active-low) | video_on, pixel_x, pixel_y, ring_active
//   cfg_we, cfg_idx, cfg_sel (0 XL,1 XR,2 YT,3 YB,4 colour,5 mode), cfg_wdata (mode: b0 en, b1 border, b2 blink)
//   graph_on, fig_RGB, box_hit: one register stage after the presented pixel
module generador_figuras_param #(
  parameter int N_BOX        = 4,
  parameter int RGB_W        = 8,
  parameter int COORD_W      = 10,
  parameter int BORDER_W     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               ring_active,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_idx,
  input  logic [2:0]         cfg_sel,
  input  logic [COORD_W-1:0] cfg_wdata,
  output logic               graph_on,
  output logic [RGB_W-1:0]   fig_RGB,
  output logic [N_BOX-1:0]   box_hit
);
  // two guard bits keep inner bounds signed and overflow-free at both ends of the range
  localparam int IW = COORD_W + 2;
  localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [COORD_W-1:0] xl [N_BOX];
  logic [COORD_W-1:0] xr [N_BOX];
  logic [COORD_W-1:0] yt [N_BOX];
  logic [COORD_W-1:0] yb [N_BOX];
  logic [RGB_W-1:0]   colour [N_BOX];
  logic [2:0]         mode [N_BOX];
  logic [N_BOX-1:0]   hit;
  logic [RGB_W-1:0]   rgb;
  logic [CW-1:0]      frame_cnt;
  logic               blink_phase, prev_origin, origin, frame_start, wrap;
  logic signed [IW-1:0] sx, sy;

  assign sx = $signed({2'b00, pixel_x});
  assign sy = $signed({2'b00, pixel_y});

  for (genvar b = 0; b < N_BOX; b++) begin : g_box
    logic signed [IW-1:0] ixl, ixr, iyt, iyb;
    logic outer, inner;
    assign ixl = $signed({2'b00, xl[b]}) + IW'(BORDER_W);
    assign ixr = $signed({2'b00, xr[b]}) - IW'(BORDER_W);
    assign iyt = $signed({2'b00, yt[b]}) + IW'(BORDER_W);
    assign iyb = $signed({2'b00, yb[b]}) - IW'(BORDER_W);
    assign outer = mode[b][0] && pixel_x >= xl[b] && pixel_x <= xr[b] && pixel_y >= yt[b] && pixel_y <= yb[b];
    // an inverted inner rectangle (box too small) is empty, so the whole box becomes border
    assign inner = sx >= ixl && sx <= ixr && sy >= iyt && sy <= iyb;
    assign hit[b] = outer && !(mode[b][1] && inner) && !(mode[b][2] && ring_active && blink_phase);
  end

  // walk from highest index down so the lowest-index hit wins
  always_comb begin
    rgb = '0;
    for (int i = N_BOX - 1; i >= 0; i--)
      if (hit[i]) rgb = colour[i];
  end

  // origin may be held for several clocks behind a pixel-tick enable; pulse only on its first clock
  assign origin      = pixel_x == '0 && pixel_y == '0;
  assign frame_start = origin && !prev_origin;
  assign wrap        = frame_start && frame_cnt == CW'(BLINK_FRAMES - 1);

  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < N_BOX; i++) begin
        xl[i]     <= COORD_W'(i == 0 ? 160 : i == 1 ? 48 : i == 2 ? 336 : 0);
        xr[i]     <= COORD_W'(i == 0 ? 479 : i == 1 ? 303 : i == 2 ? 591 : 0);
        yt[i]     <= COORD_W'(i == 0 ? 64 : i < 3 ? 352 : 0);
        yb[i]     <= COORD_W'(i == 0 ? 255 : i < 3 ? 447 : 0);
        colour[i] <= i < 3 ? RGB_W'(8'h1E) : '0;
        mode[i]   <= i == 2 ? 3'b101 : i < 2 ? 3'b001 : 3'b000;
      end
    else if (cfg_we)
      for (int i = 0; i < N_BOX; i++)
        if (cfg_idx == 3'(i)) begin
          if (cfg_sel == 3'd0) xl[i] <= cfg_wdata;
          if (cfg_sel == 3'd1) xr[i] <= cfg_wdata;
          if (cfg_sel == 3'd2) yt[i] <= cfg_wdata;
          if (cfg_sel == 3'd3) yb[i] <= cfg_wdata;
          if (cfg_sel == 3'd4) colour[i] <= cfg_wdata[RGB_W-1:0];
          if (cfg_sel == 3'd5) mode[i] <= cfg_wdata[2:0];
        end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev_origin <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      graph_on    <= 1'b0;
      fig_RGB     <= '0;
      box_hit     <= '0;
    end else begin
      prev_origin <= origin;
      frame_cnt   <= !ring_active ? '0 : wrap ? '0 : frame_start ? frame_cnt + 1'b1 : frame_cnt;
      blink_phase <= ring_active && (blink_phase ^ wrap);
      graph_on    <= video_on && |hit;
      fig_RGB     <= video_on ? rgb : '0;
      box_hit     <= video_on ? hit : '0;
    end
endmodule

// File: tb/tb_generador_figuras_param.sv
// tb_generador_figuras_param: directed self-checking bench for generador_figuras_param
module tb_generador_figuras_param;
  logic       clk = 1'b0, reset = 1'b0, video_on = 1'b0, ring_active = 1'b0, cfg_we = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0, cfg_wdata = '0;
  logic [2:0] cfg_idx = '0, cfg_sel = '0;
  logic       graph_on;
  logic [7:0] fig_RGB;
  logic [3:0] box_hit;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  generador_figuras_param #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .ring_active(ring_active), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .graph_on(graph_on), .fig_RGB(fig_RGB), .box_hit(box_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect3(input string tag, input logic g, input logic [7:0] c, input logic [3:0] h);
    chk({tag, ".graph_on"}, 32'(graph_on), 32'(g));
    chk({tag, ".fig_RGB"}, 32'(fig_RGB), 32'(c));
    chk({tag, ".box_hit"}, 32'(box_hit), 32'(h));
  endtask

  task automatic pix(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input int sel, input int data);
    cfg_we = 1'b1;
    cfg_idx = 3'(idx);
    cfg_sel = 3'(sel);
    cfg_wdata = 10'(data);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic box(input int idx, input int x0, input int x1, input int y0, input int y1);
    cfg(idx, 0, x0);
    cfg(idx, 1, x1);
    cfg(idx, 2, y0);
    cfg(idx, 3, y1);
  endtask

  task automatic frame();
    repeat (3) pix(0, 0);
    pix(400, 400);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect3("reset", 1'b0, 8'h00, 4'b0000);
    reset = 1'b1;
    video_on = 1'b1;
    pix(160, 64);  expect3("def_corner0", 1'b1, 8'h1E, 4'b0001);
    pix(159, 64);  expect3("def_left_miss", 1'b0, 8'h00, 4'b0000);
    pix(591, 447); expect3("def_corner2", 1'b1, 8'h1E, 4'b0100);
    video_on = 1'b0;
    pix(160, 64);  expect3("video_off", 1'b0, 8'h00, 4'b0000);
    video_on = 1'b1;

    box(3, 100, 200, 50, 300);
    cfg(3, 4, 8'hE0);
    cfg(3, 5, 1);
    pix(170, 100); expect3("prio_both", 1'b1, 8'h1E, 4'b1001);
    pix(120, 100); expect3("prio_box3", 1'b1, 8'hE0, 4'b1000);

    box(3, 100, 109, 100, 109);
    cfg(3, 5, 3);
    pix(101, 105); expect3("border_left", 1'b1, 8'hE0, 4'b1000);
    pix(102, 105); expect3("border_inner", 1'b0, 8'h00, 4'b0000);
    pix(107, 107); expect3("border_inner_br", 1'b0, 8'h00, 4'b0000);
    pix(108, 107); expect3("border_right", 1'b1, 8'hE0, 4'b1000);
    pix(105, 100); expect3("border_top", 1'b1, 8'hE0, 4'b1000);
    cfg(3, 1, 102);
    pix(101, 105); expect3("narrow_a", 1'b1, 8'hE0, 4'b1000);
    pix(102, 105); expect3("narrow_b", 1'b1, 8'hE0, 4'b1000);

    cfg(5, 5, 0);
    pix(100, 400); expect3("idx5_ignored", 1'b1, 8'h1E, 4'b0010);
    cfg(4, 5, 0);
    pix(160, 64);  expect3("idx4_ignored", 1'b1, 8'h1E, 4'b0001);
    cfg(0, 6, 0);
    cfg(0, 7, 0);
    pix(160, 64);  expect3("sel67_ignored", 1'b1, 8'h1E, 4'b0001);
    pixel_x = 10'd170;
    pixel_y = 10'd100;
    cfg(0, 0, 200);
    expect3("same_cycle_old", 1'b1, 8'h1E, 4'b0001);
    pix(170, 100); expect3("after_write", 1'b0, 8'h00, 4'b0000);
    cfg(0, 0, 300);
    cfg(0, 1, 200);
    pix(250, 100); expect3("inverted_a", 1'b0, 8'h00, 4'b0000);
    pix(200, 100); expect3("inverted_b", 1'b0, 8'h00, 4'b0000);

    ring_active = 1'b1;
    pix(400, 400); expect3("blink_f0", 1'b1, 8'h1E, 4'b0100);
    frame();       expect3("blink_f1", 1'b1, 8'h1E, 4'b0100);
    frame();       expect3("blink_f2", 1'b0, 8'h00, 4'b0000);
    frame();       expect3("blink_f3", 1'b0, 8'h00, 4'b0000);
    frame();       expect3("blink_f4", 1'b1, 8'h1E, 4'b0100);
    frame();       expect3("blink_f5", 1'b1, 8'h1E, 4'b0100);
    frame();       expect3("blink_f6", 1'b0, 8'h00, 4'b0000);
    ring_active = 1'b0;
    pix(400, 400); expect3("ring_drop", 1'b1, 8'h1E, 4'b0100);
    ring_active = 1'b1;
    pix(400, 400); expect3("ring_restart", 1'b1, 8'h1E, 4'b0100);
    frame();       expect3("restart_f1", 1'b1, 8'h1E, 4'b0100);
    frame();       expect3("restart_f2", 1'b0, 8'h00, 4'b0000);
    ring_active = 1'b0;

    pix(101, 105); expect3("pre_reset", 1'b1, 8'hE0, 4'b1000);
    #2;
    reset = 1'b0;
    #1;
    expect3("async_reset", 1'b0, 8'h00, 4'b0000);
    @(posedge clk);
    #1;
    expect3("reset_held", 1'b0, 8'h00, 4'b0000);
    reset = 1'b1;
    pix(101, 105); expect3("box3_cleared", 1'b0, 8'h00, 4'b0000);
    pix(160, 64);  expect3("box0_restored", 1'b1, 8'h1E, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
